// File: rtl/mem_arbiter.sv
// mem_arbiter: two-state arbiter that shares one RAM port between the
// instruction and data ports of two cores.
//
// Ports
//   CLK                 clock, all state changes on its rising edge
//   nRST                asynchronous active-low reset
//   iREN, iaddr         per-core instruction read request and address
//   iwait, iload        per-core instruction wait (1 = not done) and read data
//   dREN, dWEN          per-core data read / write requests
//   daddr, dstore       per-core data address and store data
//   dwait, dload        per-core data wait (1 = not done) and load data
//   ramREN, ramWEN      RAM read / write enables
//   ramaddr, ramstore   RAM address and store data
//   ramload             RAM read data
//   ramstate            RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   err_count           saturating count of ERROR responses seen while serving
module mem_arbiter #(
    parameter int CORES = 2,
    parameter int ERRW  = 8
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic [CORES-1:0]            iREN,
    input  logic [CORES-1:0][31:0]      iaddr,
    output logic [CORES-1:0]            iwait,
    output logic [CORES-1:0][31:0]      iload,
    input  logic [CORES-1:0]            dREN,
    input  logic [CORES-1:0]            dWEN,
    input  logic [CORES-1:0][31:0]      daddr,
    input  logic [CORES-1:0][31:0]      dstore,
    output logic [CORES-1:0]            dwait,
    output logic [CORES-1:0][31:0]      dload,
    output logic                        ramREN,
    output logic                        ramWEN,
    output logic [31:0]                 ramaddr,
    output logic [31:0]                 ramstore,
    input  logic [31:0]                 ramload,
    input  logic [1:0]                  ramstate,
    output logic [ERRW-1:0]             err_count
);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic {IDLE, SERVE} state_t;

    state_t           state, next_state;
    logic             g_core, g_data, g_write, last_core;
    logic             n_core, n_data, n_write;
    logic             pref, any_req, active, done, err_hit;
    logic [CORES-1:0] d_req;

    // A data port is requesting on either enable; data beats instruction
    // regardless of core, and within a class the core not served last wins.
    assign d_req   = dREN | dWEN;
    assign pref    = ~last_core;
    assign any_req = (|d_req) | (|iREN);
    assign n_data  = |d_req;
    assign n_core  = n_data ? (d_req[pref] ? pref : ~pref) : (iREN[pref] ? pref : ~pref);
    assign n_write = n_data & dWEN[n_core];

    // The granted request must still be present; if it drops, the transfer
    // is abandoned without signalling completion.
    assign active  = g_data ? d_req[g_core] : iREN[g_core];
    assign done    = (state == SERVE) && active && (ramstate == RAM_ACCESS);
    assign err_hit = (state == SERVE) && active && (ramstate == RAM_ERROR);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            last_core <= 1'b1;
            g_core    <= 1'b0;
            g_data    <= 1'b0;
            g_write   <= 1'b0;
            err_count <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && any_req) begin
                g_core    <= n_core;
                g_data    <= n_data;
                g_write   <= n_write;
                last_core <= n_core;
            end
            if (err_hit && err_count != '1)
                err_count <= err_count + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = '1;
        dwait      = '1;
        iload      = '0;
        dload      = '0;
        if (state == IDLE) begin
            next_state = any_req ? SERVE : IDLE;
        end else begin
            ramWEN     = g_write;
            ramREN     = ~g_write;
            ramaddr    = g_data ? daddr[g_core] : iaddr[g_core];
            ramstore   = g_data ? dstore[g_core] : '0;
            next_state = (!active || ramstate == RAM_ACCESS) ? IDLE : SERVE;
            if (done && g_data) begin
                dwait[g_core] = 1'b0;
                dload[g_core] = ramload;
            end
            if (done && !g_data) begin
                iwait[g_core] = 1'b0;
                iload[g_core] = ramload;
            end
        end
    end
endmodule
